// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// the sizing helper for the bit counter.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter width for WIDTH bit positions; never narrower than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full-adder cell; the additive twin of the subtractor
// bit cell.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first,
// through a single full-adder cell and a carry flop.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_full;

    full_adder_bit u_fa (
        .x  (a_sh_reg[0]),
        .y  (b_sh_reg[0]),
        .ci (carry_reg),
        .s  (fa_s),
        .co (fa_co)
    );

    // The final sum bit goes straight into the result register, so the
    // partial-sum shifter only needs to hold the WIDTH-1 earlier bits.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_full = fa_s;
        end else begin : g_sum_wn
            logic [WIDTH-2:0] sum_sh_reg;

            assign sum_full = {fa_s, sum_sh_reg};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_sh_reg <= '0;
                end else if (state_reg == SHIFT) begin
                    sum_sh_reg <= sum_full[WIDTH-1:1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                // DONE accepts a new start exactly like IDLE (back-to-back).
                IDLE, DONE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= SHIFT;
                    end else begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh_reg  <= a_sh_reg >> 1;
                    b_sh_reg  <= b_sh_reg >> 1;
                    carry_reg <= fa_co;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        sum       <= sum_full;
                        cout      <= fa_co;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4) using an expected-result
// queue filled at start and drained when done pulses.
module tb_serial_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic [W:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int done_count = 0;
    int busy_count = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_count++;
        if (busy === 1'b1) busy_count++;
    end

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Called at a falling edge; holds start for one rising edge, then scrambles inputs.
    task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc, input bit push);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        if (push) exp_q.push_back(model(ta, tb_v, tc));
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_done(output int cycles, output bit ok);
        ok = 0;
        cycles = 0;
        while (!ok && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (done === 1'b1) ok = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, cout, sum} !== '0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b cout=%b sum=%b, required all 0", busy, done, cout, sum);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_no_carry();
        int b0, cyc;
        bit ok;
        logic [W:0] e;
        @(negedge clk);
        b0 = busy_count;
        drive_start(4'b0111, 4'b0110, 1'b0, 1);
        wait_done(cyc, ok);
        checks++;
        if (!ok) begin
            failures++; exp_q.delete();
            $display("FAIL no_carry_timeout: done not seen in %0d cycles", cyc);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if ({cout, sum} !== e) begin
                failures++;
                $display("FAIL no_carry_result: got %b_%b required %b_%b", cout, sum, e[W], e[W-1:0]);
            end
            checks++;
            if (cyc != W) begin
                failures++;
                $display("FAIL no_carry_latency: done after %0d cycles, required %0d", cyc, W);
            end
            checks++;
            if (busy_count - b0 != W) begin
                failures++;
                $display("FAIL no_carry_busy: busy for %0d cycles, required %0d", busy_count - b0, W);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL done_pulse_width: done=%b one cycle later, required 0", done);
            end
        end
    endtask

    task automatic test_carry_out();
        logic [W-1:0] va[2] = '{4'b1101, 4'b1100};
        logic [W-1:0] vb[2] = '{4'b0101, 4'b1011};
        int cyc;
        bit ok;
        logic [W:0] e;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_start(va[i], vb[i], 1'b0, 1);
            wait_done(cyc, ok);
            checks++;
            if (!ok) begin
                failures++; exp_q.delete();
                $display("FAIL carry_out_timeout[%0d]: done not seen", i);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if ({cout, sum} !== e) begin
                    failures++;
                    $display("FAIL carry_out_result[%0d]: got %b_%b required %b_%b", i, cout, sum, e[W], e[W-1:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int d0;
        @(negedge clk);
        drive_start(4'b0111, 4'b0110, 1'b0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cout, sum} !== '0) begin
            failures++;
            $display("FAIL reset_mid_op: busy=%b done=%b cout=%b sum=%b, required all 0", busy, done, cout, sum);
        end
        exp_q.delete();
        d0 = done_count;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (done_count != d0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done: %0d done pulses busy=%b after reset, required 0 and 0", done_count - d0, busy);
        end
    endtask

    task automatic test_full_chain();
        int cyc;
        bit ok;
        logic [W:0] e;
        @(negedge clk);
        drive_start(4'b1111, 4'b0000, 1'b1, 1);
        wait_done(cyc, ok);
        checks++;
        if (!ok) begin
            failures++; exp_q.delete();
            $display("FAIL full_chain_timeout: done not seen");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if ({cout, sum} !== e) begin
                failures++;
                $display("FAIL full_chain_result: got %b_%b required %b_%b", cout, sum, e[W], e[W-1:0]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int b0, d0, cyc;
        bit ok;
        logic [W:0] e;
        @(negedge clk);
        b0 = busy_count; d0 = done_count;
        drive_start(4'b0100, 4'b0011, 1'b0, 1);
        drive_start(4'b1111, 4'b1111, 1'b0, 0);
        wait_done(cyc, ok);
        checks++;
        if (!ok) begin
            failures++; exp_q.delete();
            $display("FAIL ignore_timeout: done not seen");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if ({cout, sum} !== e) begin
                failures++;
                $display("FAIL ignore_result: got %b_%b required %b_%b", cout, sum, e[W], e[W-1:0]);
            end
        end
        repeat (8) @(negedge clk);
        checks++;
        if (busy_count - b0 != W || done_count - d0 != 1) begin
            failures++;
            $display("FAIL ignore_single_op: busy %0d cycles, %0d done pulses; required %0d and 1", busy_count - b0, done_count - d0, W);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit ok;
        logic [W:0] e;
        @(negedge clk);
        drive_start(4'b0101, 4'b0010, 1'b0, 1);
        wait_done(cyc, ok);
        checks++;
        if (!ok) begin
            failures++; exp_q.delete();
            $display("FAIL b2b_first_timeout: done not seen");
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if ({cout, sum} !== e) begin
            failures++;
            $display("FAIL b2b_first_result: got %b_%b required %b_%b", cout, sum, e[W], e[W-1:0]);
        end
        drive_start(4'b0011, 4'b0110, 1'b0, 1);
        checks++;
        if ({cout, sum} !== e || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_hold: got %b_%b busy=%b, required %b_%b busy=1", cout, sum, busy, e[W], e[W-1:0]);
        end
        wait_done(cyc, ok);
        checks++;
        if (!ok || cyc + 1 != W + 1) begin
            failures++; exp_q.delete();
            $display("FAIL b2b_latency: second done %0d cycles after first (seen=%0d), required %0d", cyc + 1, ok, W + 1);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if ({cout, sum} !== e) begin
                failures++;
                $display("FAIL b2b_second_result: got %b_%b required %b_%b", cout, sum, e[W], e[W-1:0]);
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        bit ok;
        logic [W:0] e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_start(W'($urandom), W'($urandom), 1'($urandom), 1);
            wait_done(cyc, ok);
            checks++;
            if (!ok) begin
                failures++; exp_q.delete();
                $display("FAIL random_timeout[%0d]: done not seen", i);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if ({cout, sum} !== e) begin
                    failures++;
                    $display("FAIL random_result[%0d]: got %b_%b required %b_%b", i, cout, sum, e[W], e[W-1:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_carry();
        test_carry_out();
        test_reset_mid_op();
        test_full_chain();
        test_start_ignored();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
